// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int CNT_W       = 8;
  localparam int DEF_NUM_REQ = 4;

  // Round-robin successor with explicit wrap so non-power-of-2 counts work.
  function automatic int next_ptr(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N     = DEF_NUM_REQ,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_pick,
  output logic [PTR_W-1:0] o_idx
);

  int               w_sum;
  logic [PTR_W-1:0] w_j;
  logic             w_found;

  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = 0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_j = PTR_W'(w_sum);
      if (!w_found && i_req[w_j]) begin
        w_found     = 1'b1;
        o_pick[w_j] = 1'b1;
        o_idx       = w_j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the uart_fifo transmit port.
// Define UART_ARB_PRIO_EN to give requester 0 strict priority when idle.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_byte,
  output logic                 transmit,
  input  logic                 tx_fifo_full,
  output logic                 burst_drop
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_TIMEOUT - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]   r_burst, w_burst_nxt;
  logic [CNT_W-1:0]   r_stall, w_stall_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [7:0]         r_tx_byte, w_tx_byte_nxt;
  logic               r_transmit, w_transmit_nxt;
  logic               r_drop, w_drop_nxt;

  logic [NUM_REQ-1:0] w_pick, w_win_onehot;
  logic [PTR_W-1:0]   w_pick_idx, w_win_idx, w_ptr_inc, w_ptr_after;
  logic               w_owner_valid, w_owner_last, w_accept;
  logic [7:0]         w_owner_data;

  uart_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx)
  );

  assign w_ptr_inc = PTR_W'(next_ptr(int'(r_owner), NUM_REQ));

`ifdef UART_ARB_PRIO_EN
  assign w_win_onehot = req_valid[0] ? NUM_REQ'(1) : w_pick;
  assign w_win_idx    = req_valid[0] ? '0 : w_pick_idx;
  assign w_ptr_after  = (r_owner == '0) ? r_ptr : w_ptr_inc;
`else
  assign w_win_onehot = w_pick;
  assign w_win_idx    = w_pick_idx;
  assign w_ptr_after  = w_ptr_inc;
`endif

  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_last  = 1'b0;
    w_owner_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == r_owner) begin
        w_owner_valid = req_valid[i];
        w_owner_last  = req_last[i];
        w_owner_data  = req_data[i*8 +: 8];
      end
    end
  end

  // Holding off after each strobe absorbs the one-cycle lag of tx_fifo_full.
  assign w_accept  = (r_state == ARB_LOCKED) && w_owner_valid && !tx_fifo_full && !r_transmit;
  assign req_ready = w_accept ? r_grant : '0;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_burst_nxt    = r_burst;
    w_stall_nxt    = r_stall;
    w_grant_nxt    = r_grant;
    w_tx_byte_nxt  = 8'h00;
    w_transmit_nxt = 1'b0;
    w_drop_nxt     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (|req_valid) begin
          w_state_nxt = ARB_LOCKED;
          w_owner_nxt = w_win_idx;
          w_grant_nxt = w_win_onehot;
          w_burst_nxt = '0;
          w_stall_nxt = '0;
        end
      end
      ARB_LOCKED: begin
        if (w_accept) begin
          w_transmit_nxt = 1'b1;
          w_tx_byte_nxt  = w_owner_data;
        end
        if (w_accept && w_owner_last) begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_after;
        end else if ((w_accept && r_burst == BURST_LAST) ||
                     (!w_owner_valid && r_stall == STALL_LAST)) begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_after;
          w_drop_nxt  = 1'b1;
        end else if (w_accept) begin
          w_burst_nxt = r_burst + CNT_W'(1);
          w_stall_nxt = '0;
        end else if (!w_owner_valid) begin
          w_stall_nxt = r_stall + CNT_W'(1);
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ARB_IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_burst    <= '0;
      r_stall    <= '0;
      r_grant    <= '0;
      r_tx_byte  <= 8'h00;
      r_transmit <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_burst    <= w_burst_nxt;
      r_stall    <= w_stall_nxt;
      r_grant    <= w_grant_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_transmit <= w_transmit_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  assign grant      = r_grant;
  assign tx_byte    = r_tx_byte;
  assign transmit   = r_transmit;
  assign burst_drop = r_drop;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic vs a packet-level model.
// Honours UART_ARB_PRIO_EN when compiled with it.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int MAXB = 4;
  localparam int TOUT = 8;

  logic                CLK = 1'b0;
  logic                RESET;
  logic [NREQ-1:0]     req_valid, req_last, req_ready, grant;
  logic [8*NREQ-1:0]   req_data;
  logic [7:0]          tx_byte;
  logic                transmit, tx_fifo_full, burst_drop;

  int testsRun = 0;
  int testsFailed = 0;
  int cycle = 0;

  byte unsigned srcQ[NREQ][$];
  bit           srcLastQ[NREQ][$];
  bit           srcEn[NREQ];

  // Reference model: owner index (-1 when idle), pointer and counters as plain ints.
  int          mOwner, mPtr, mBurst, mStall;
  logic [NREQ-1:0] mGrant, mReady;
  logic [7:0]  mTx;
  logic        mTransmit, mDrop;

  byte unsigned    txLog[$];
  int              pulseLog[$];
  logic [NREQ-1:0] grantLog[$];
  int rr, len, n;
  bit seen;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .MAX_BURST(MAXB), .STALL_TIMEOUT(TOUT)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .tx_byte      (tx_byte),
    .transmit     (transmit),
    .tx_fifo_full (tx_fifo_full),
    .burst_drop   (burst_drop)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      bit v;
      v = srcEn[i] && (srcQ[i].size() > 0);
      req_valid[i]       = v;
      req_data[i*8 +: 8] = v ? srcQ[i][0] : 8'h00;
      req_last[i]        = v ? srcLastQ[i][0] : 1'b0;
    end
  endtask

  task automatic pushByte(input int r, input byte unsigned b, input bit last);
    srcQ[r].push_back(b);
    srcLastQ[r].push_back(last);
  endtask

  task automatic modelReset();
    mOwner = -1; mPtr = 0; mBurst = 0; mStall = 0;
    mGrant = '0; mTx = 8'h00; mTransmit = 1'b0; mDrop = 1'b0;
  endtask

  // Advances the model one clock using the inputs currently driven.
  task automatic modelStep();
    int g, w;
    bit acc, rel, prio;
    prio = 1'b0;
`ifdef UART_ARB_PRIO_EN
    prio = 1'b1;
`endif
    if (RESET) begin
      modelReset();
    end else if (mOwner < 0) begin
      mTransmit = 1'b0; mTx = 8'h00; mDrop = 1'b0;
      if (|req_valid) begin
        w = -1;
        if (prio && req_valid[0]) w = 0;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_valid[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
        mOwner = w; mGrant = '0; mGrant[w] = 1'b1; mBurst = 0; mStall = 0;
      end
    end else begin
      g = mOwner;
      acc = mReady[g];
      mTransmit = acc;
      mTx = acc ? req_data[g*8 +: 8] : 8'h00;
      mDrop = 1'b0;
      rel = 1'b0;
      if (acc && req_last[g]) rel = 1'b1;
      else if (acc && mBurst == MAXB - 1) begin rel = 1'b1; mDrop = 1'b1; end
      else if (!req_valid[g] && mStall == TOUT - 1) begin rel = 1'b1; mDrop = 1'b1; end
      if (rel) begin
        mOwner = -1; mGrant = '0;
        if (!(prio && g == 0)) mPtr = (g + 1) % NREQ;
      end else if (acc) begin
        mBurst++; mStall = 0;
      end else if (!req_valid[g]) begin
        mStall++;
      end
    end
  endtask

  task automatic tick();
    logic [NREQ-1:0] popMask;
    @(negedge CLK);
    mReady = '0;
    if (mOwner >= 0 && req_valid[mOwner] && !tx_fifo_full && !mTransmit) mReady[mOwner] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(mReady));
    checkOutput("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    popMask = RESET ? '0 : mReady;
    modelStep();
    @(posedge CLK);
    #1;
    cycle++;
    checkOutput("grant", 32'(grant), 32'(mGrant));
    checkOutput("tx_byte", 32'(tx_byte), 32'(mTx));
    checkOutput("transmit", 32'(transmit), 32'(mTransmit));
    checkOutput("burst_drop", 32'(burst_drop), 32'(mDrop));
    if (transmit === 1'b1) begin
      txLog.push_back(tx_byte);
      pulseLog.push_back(cycle);
    end
    if (grant !== '0 && (grantLog.size() == 0 || grantLog[$] !== grant)) grantLog.push_back(grant);
    for (int i = 0; i < NREQ; i++)
      if (popMask[i] && srcQ[i].size() > 0) begin
        void'(srcQ[i].pop_front());
        void'(srcLastQ[i].pop_front());
      end
    applyStimulus();
  endtask

  task automatic doReset();
    for (int i = 0; i < NREQ; i++) begin
      srcQ[i].delete(); srcLastQ[i].delete(); srcEn[i] = 1'b1;
    end
    tx_fifo_full = 1'b0;
    RESET = 1'b1;
    applyStimulus();
    tick();
    RESET = 1'b0;
    txLog.delete(); pulseLog.delete(); grantLog.delete();
  endtask

  task automatic runTicks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    $display("[TB] start");
    for (int i = 0; i < NREQ; i++) srcEn[i] = 1'b1;
    tx_fifo_full = 1'b0;
    RESET = 1'b1;
    applyStimulus();
    repeat (2) @(posedge CLK);
    #1;
    modelReset();
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_tx_byte", 32'(tx_byte), 32'd0);
    checkOutput("reset_transmit", 32'(transmit), 32'd0);
    checkOutput("reset_burst_drop", 32'(burst_drop), 32'd0);
    RESET = 1'b0;

    // Single packet from requester 0.
    doReset();
    pushByte(0, 8'h57, 0); pushByte(0, 8'h41, 0); pushByte(0, 8'h53, 1);
    applyStimulus();
    runTicks(12);
    checkOutput("t1_count", 32'(txLog.size()), 32'd3);
    checkOutput("t1_byte0", 32'(txLog[0]), 32'h57);
    checkOutput("t1_byte1", 32'(txLog[1]), 32'h41);
    checkOutput("t1_byte2", 32'(txLog[2]), 32'h53);
    checkOutput("t1_gap01", 32'(pulseLog[1] - pulseLog[0]), 32'd2);
    checkOutput("t1_gap12", 32'(pulseLog[2] - pulseLog[1]), 32'd2);
    checkOutput("t1_grant_idle", 32'(grant), 32'd0);
    // Pointer moved to 1: requester 1 beats requester 0 next.
    grantLog.delete();
    pushByte(0, 8'h10, 1); pushByte(1, 8'h11, 1);
    applyStimulus();
    runTicks(10);
`ifdef UART_ARB_PRIO_EN
    checkOutput("t1_next_owner", 32'(grantLog[0]), 32'b0001);
`else
    checkOutput("t1_next_owner", 32'(grantLog[0]), 32'b0010);
`endif

    // Contention between requesters 1 and 3.
    doReset();
    pushByte(1, 8'hA1, 0); pushByte(1, 8'hA2, 1);
    pushByte(3, 8'hB1, 0); pushByte(3, 8'hB2, 1);
    applyStimulus();
    runTicks(14);
    checkOutput("t2_count", 32'(txLog.size()), 32'd4);
    checkOutput("t2_b0", 32'(txLog[0]), 32'hA1);
    checkOutput("t2_b1", 32'(txLog[1]), 32'hA2);
    checkOutput("t2_b2", 32'(txLog[2]), 32'hB1);
    checkOutput("t2_b3", 32'(txLog[3]), 32'hB2);
    checkOutput("t2_owner0", 32'(grantLog[0]), 32'b0010);
    checkOutput("t2_owner1", 32'(grantLog[1]), 32'b1000);

    // Back-pressure mid-packet.
    doReset();
    pushByte(2, 8'hC1, 0); pushByte(2, 8'hC2, 0); pushByte(2, 8'hC3, 1);
    applyStimulus();
    n = 0;
    while (txLog.size() < 1 && n < 10) begin tick(); n++; end
    checkOutput("t3_first_byte", 32'(txLog.size()), 32'd1);
    tx_fifo_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checkOutput("t3_no_transmit", 32'(transmit), 32'd0);
      checkOutput("t3_grant_held", 32'(grant), 32'b0100);
      checkOutput("t3_no_drop", 32'(burst_drop), 32'd0);
    end
    tx_fifo_full = 1'b0;
    runTicks(10);
    checkOutput("t3_count", 32'(txLog.size()), 32'd3);
    checkOutput("t3_b2", 32'(txLog[2]), 32'hC3);

    // Stall timeout, then pending requester 0 is served.
    doReset();
    pushByte(2, 8'h3C, 0);
    applyStimulus();
    n = 0;
    while (txLog.size() < 1 && n < 10) begin tick(); n++; end
    pushByte(0, 8'h11, 1);
    applyStimulus();
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      tick(); n++;
      if (burst_drop === 1'b1) seen = 1'b1;
    end
    checkOutput("t4_drop_seen", 32'(seen), 32'd1);
    checkOutput("t4_drop_delay", 32'(n), 32'd8);
    checkOutput("t4_grant_released", 32'(grant), 32'd0);
    tick();
    checkOutput("t4_regrant_req0", 32'(grant), 32'b0001);
    runTicks(6);

    // Burst limit, then reset during the re-grant.
    doReset();
    for (int b = 0; b < 6; b++) pushByte(0, 8'(8'hD0 + b), b == 5);
    applyStimulus();
    n = 0; seen = 1'b0;
    while (!seen && n < 30) begin
      tick(); n++;
      if (burst_drop === 1'b1) seen = 1'b1;
    end
    checkOutput("t5_drop_seen", 32'(seen), 32'd1);
    checkOutput("t5_count", 32'(txLog.size()), 32'd4);
    checkOutput("t5_last_byte", 32'(tx_byte), 32'hD3);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checkOutput("t5_rst_grant", 32'(grant), 32'd0);
    checkOutput("t5_rst_transmit", 32'(transmit), 32'd0);
    checkOutput("t5_rst_tx_byte", 32'(tx_byte), 32'd0);
    checkOutput("t5_rst_drop", 32'(burst_drop), 32'd0);

    // Reset on the same edge as an accept cancels the strobe.
    doReset();
    pushByte(1, 8'h77, 1);
    applyStimulus();
    n = 0;
    while (grant === '0 && n < 5) begin tick(); n++; end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checkOutput("rst_cancel_transmit", 32'(transmit), 32'd0);
    checkOutput("rst_cancel_tx_byte", 32'(tx_byte), 32'd0);

`ifdef UART_ARB_PRIO_EN
    // Priority: requester 0 wins with pointer at 2 and leaves the pointer there.
    doReset();
    pushByte(1, 8'h21, 1);
    applyStimulus();
    runTicks(6);
    grantLog.delete();
    pushByte(0, 8'h30, 1); pushByte(1, 8'h31, 1); pushByte(2, 8'h32, 1);
    applyStimulus();
    runTicks(20);
    checkOutput("t6_owner0", 32'(grantLog[0]), 32'b0001);
    checkOutput("t6_owner1", 32'(grantLog[1]), 32'b0100);
    checkOutput("t6_owner2", 32'(grantLog[2]), 32'b0010);
`endif

    // Randomized traffic with back-pressure, stalls and occasional reset.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        rr = $urandom_range(NREQ - 1);
        len = $urandom_range(6, 1);
        if (srcQ[rr].size() < 16)
          for (int b = 0; b < len; b++) pushByte(rr, 8'($urandom), b == len - 1);
      end
      if ($urandom_range(15) == 0) begin
        rr = $urandom_range(NREQ - 1);
        srcEn[rr] = !srcEn[rr];
      end
      tx_fifo_full = ($urandom_range(3) == 0);
      RESET = ($urandom_range(399) == 0);
      applyStimulus();
      tick();
    end
    RESET = 1'b0;
    tx_fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) srcEn[i] = 1'b1;
    applyStimulus();
    runTicks(200);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single tx_byte/transmit port of uart_fifo between NUM_REQ byte-stream requesters, such as the key echo path, game status messages and debug dumps.
- Round-robin grant with packet lock: a granted requester keeps the port until it sends a byte flagged last.
- A grant is also released on stall timeout or when the burst limit is reached.
- Sits between the game-side message sources and uart_fifo; consumes tx_fifo_full.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, max bytes per grant before forced release (1..255)
STALL_TIMEOUT, 255, cycles a granted requester may hold valid low before release (1..255)

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  requester i has a byte on req_data
req_data  input  8*NUM_REQ  byte i at bits [8i+7:8i]
req_last  input  NUM_REQ  byte i is the final byte of its packet
req_ready  output  NUM_REQ  byte i accepted this cycle (combinational)
grant  output  NUM_REQ  one-hot current owner, 0 when idle (registered)
tx_byte  output  8  byte to uart_fifo (registered)
transmit  output  1  one-cycle write strobe to uart_fifo (registered)
tx_fifo_full  input  1  uart_fifo TX FIFO full
burst_drop  output  1  one-cycle pulse on forced release (timeout or burst limit)

Behaviour:
Reset values:
- grant=0, tx_byte=0, transmit=0, burst_drop=0.
- rr_ptr=0, burst_cnt=0, stall_cnt=0.
- State is IDLE.

IDLE:
- If any req_valid is high, the winner is the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
- Next cycle: grant is one-hot on the winner, state is LOCKED, and both counters are cleared.
- No byte is accepted in the IDLE cycle, so there is 1 cycle of arbitration latency.

LOCKED, owner g:
- accept = req_valid[g] & !tx_fifo_full & !transmit. req_ready[g] = accept; all other req_ready bits are 0.
- On accept:
  - Next cycle: tx_byte=req_data[g], transmit=1.
  - burst_cnt increments and stall_cnt clears.
- Otherwise transmit=0 and tx_byte=0.
- transmit is never high on two consecutive cycles. This absorbs the one-cycle lag of tx_fifo_full.
- If req_valid[g] is low, stall_cnt increments.
- Stall caused by tx_fifo_full does not count toward the timeout.
- Release conditions, evaluated in priority order; each returns to IDLE the next cycle with grant=0:
  1. accept & req_last[g]: rr_ptr=(g+1) mod NUM_REQ.
  2. accept & burst_cnt==MAX_BURST-1: forced release, burst_drop pulses, rr_ptr=(g+1) mod NUM_REQ.
  3. stall_cnt==STALL_TIMEOUT-1 with valid low: forced release, burst_drop pulses, rr_ptr=(g+1) mod NUM_REQ.
- After a forced release the requester re-arbitrates normally. Its packet is not discarded; continuation is the source's problem.

Boundary conditions:
- Simultaneous requests: exactly one winner; no two grant bits are ever set.
- Requester drops valid while not granted: no effect.
- tx_fifo_full held high indefinitely: the owner keeps the grant with no timeout.
- RESET mid-packet:
  - Outputs return to reset values on the next edge.
  - A transmit asserted on the same edge is cancelled.
- Width rules:
  - burst_cnt and stall_cnt are 8 bits.
  - rr_ptr is clog2(NUM_REQ) bits with explicit wrap for non-power-of-2 NUM_REQ.
- The state machine uses 2 states, IDLE and LOCKED.

Optional Feature:
UART_ARB_PRIO_EN:
- Defined: requester 0 has strict priority in IDLE and wins whenever valid, regardless of rr_ptr.
  - Requester 0 still cannot pre-empt a LOCKED owner.
  - Granting requester 0 does not move rr_ptr.
- Undefined: pure round-robin as above.

Decomposition:
Package uart_arb_pkg:
- state enum {ARB_IDLE, ARB_LOCKED}
- CNT_W=8
- default NUM_REQ
- function next_ptr(ptr, n)

Sub-module uart_rr_pick:
- Combinational round-robin picker.
- Inputs: req vector, rr_ptr. Outputs: one-hot pick and its index.
- Reused by future SPI/VGA-text arbiters.

Test Plan:
1. Single packet: req0 sends 0x57,0x41,0x53 with last on 0x53, full=0.
   -> Exactly three transmit pulses, each separated by one idle cycle, with tx_byte=0x57,0x41,0x53.
   -> grant returns to 0; rr_ptr=1.
2. Contention: req1 and req3 both valid from reset, 2-byte packets each.
   -> req1 is granted first and its packet completes atomically, then req3.
   -> No interleaving; grant never has two bits set.
3. Back-pressure: tx_fifo_full=1 for 40 cycles mid-packet.
   -> No transmit while full; grant held; no burst_drop.
   -> Transmission resumes after full drops.
4. Stall timeout: STALL_TIMEOUT=8; req2 is granted, sends one byte, then drops valid.
   -> burst_drop pulses 8 cycles after valid falls; grant=0.
   -> A pending req0 is granted next.
5. Burst limit and reset: MAX_BURST=4, req0 sends a 6-byte packet.
   -> Forced release after the 4th byte, with burst_drop.
   -> Assert RESET during the re-grant: all outputs are 0 next cycle.
6. With UART_ARB_PRIO_EN: rr_ptr=2, req0 and req2 valid in IDLE.
   -> req0 is granted; rr_ptr stays 2 after req0 releases.
